// File: rtl/fifo_fwft_adapter_if.sv
// Read-port bundle between the async FIFO, the FWFT adapter and the stream consumer.
interface fifo_fwft_adapter_if #(
  parameter int unsigned DW = 16
) ();
  localparam int unsigned LW = 2;

  logic          fifo_rden;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [LW-1:0] m_level;

  // Adapter side: drives the FIFO read strobe and the output stream
  modport master (
    output fifo_rden,
    input  fifo_empty,
    input  fifo_rdata,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_level
  );

  // Environment side: FIFO read port plus the consumer
  modport slave (
    input  fifo_rden,
    output fifo_empty,
    output fifo_rdata,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_level
  );
endinterface

// File: rtl/fifo_fwft_adapter.sv
// First-word-fall-through adapter for a registered-read FIFO port.
// Two-entry skid buffer (out + spare) with credit-based read issue so the
// stream runs at one word per clk without bubbles or overflow.
module fifo_fwft_adapter #(
  parameter int unsigned DW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_fwft_adapter_if.master bus
);

  localparam int unsigned LW = 2;
  localparam logic [LW-1:0] SLOTS_FULL = LW'(2);

  typedef enum logic [LW-1:0] {
    L0 = 2'd0,
    L1 = 2'd1,
    L2 = 2'd2
  } level_e;

  level_e        state_q, state_d;
  logic          inflight_q;
  logic          valid_q, valid_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] spare_q, spare_d;

  logic          pop_c;
  logic          rden_c;
  logic [LW-1:0] slots_c;

  // Credit check: held words plus the read in flight must never exceed two
  assign pop_c   = valid_q && bus.m_ready;
  assign slots_c = LW'(state_q) + LW'(inflight_q);
  assign rden_c  = rst_n && !bus.fifo_empty &&
                   ((slots_c < SLOTS_FULL) || ((slots_c == SLOTS_FULL) && pop_c));

  // Next level and skid-buffer contents from capture/pop events
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    spare_d = spare_q;
    case (state_q)
      L0: begin
        if (inflight_q) begin
          out_d   = bus.fifo_rdata;
          state_d = L1;
        end
      end
      L1: begin
        if (inflight_q) begin
          if (pop_c) begin
            out_d = bus.fifo_rdata;
          end else begin
            spare_d = bus.fifo_rdata;
            state_d = L2;
          end
        end else if (pop_c) begin
          state_d = L0;
        end
      end
      L2: begin
        // capture without pop cannot happen here: the credit rule blocks it
        if (pop_c) begin
          out_d = spare_q;
          if (inflight_q) begin
            spare_d = bus.fifo_rdata;
          end else begin
            state_d = L1;
          end
        end
      end
      default: begin
        state_d = L0;
      end
    endcase
    valid_d = (state_d != L0);
  end

  // State, in-flight tracker and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= L0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      out_q      <= '0;
      spare_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rden_c;
      valid_q    <= valid_d;
      out_q      <= out_d;
      spare_q    <= spare_d;
    end
  end

  assign bus.fifo_rden = rden_c;
  assign bus.m_valid   = valid_q;
  assign bus.m_data    = out_q;
  assign bus.m_level   = LW'(state_q);

endmodule
